// File: rtl/viterbi_chk_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_chk_pkg
// Shared types and helpers for the Viterbi BER checker.
//   chk_state_e  : checker state (IDLE, FILL, SEARCH, LOCKED)
//   relock_ct_t  : width of the saturating lock-loss counter
//   popcount()   : number of set bits among the low nch lanes of a mask
// -----------------------------------------------------------------------------
package viterbi_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_LOCKED = 2'd3
    } chk_state_e;

    // Widest lane count popcount() accepts; callers zero-extend their mask.
    localparam int MAX_LANES = 64;
    localparam int RELOCK_W  = 8;

    typedef logic [RELOCK_W-1:0] relock_ct_t;

    function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v, input int nch);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < nch) begin
                n += {31'd0, v[i]};
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/viterbi_chk_if.sv
// -----------------------------------------------------------------------------
// viterbi_chk_if
// Sample stream into the BER checker: one strobe qualifying a reference word
// (encoder input) and the matching decoder output word.
//   en_i  : sample strobe
//   ref_i : original data, NCH lanes
//   dut_i : decoded data, NCH lanes
// master drives the stream, slave (the checker) consumes it.
// -----------------------------------------------------------------------------
interface viterbi_chk_if #(
    parameter int NCH = 1
);
    logic           en_i;
    logic [NCH-1:0] ref_i;
    logic [NCH-1:0] dut_i;

    modport master (output en_i, ref_i, dut_i);
    modport slave  (input  en_i, ref_i, dut_i);
endinterface

// File: rtl/viterbi_hist_buf.sv
// -----------------------------------------------------------------------------
// viterbi_hist_buf
// DEPTH x NCH circular history of the reference stream with a delayed read
// port returning the entry i_lat writes back (hist[wptr - i_lat], taken before
// this cycle's write). i_lat == 0 bypasses the memory and returns i_wr_data.
//   clk, rst   : clock, synchronous active-high reset
//   i_clr      : restart; empties the buffer (fill and pointer to 0)
//   i_wr_en    : write i_wr_data at the write pointer and advance it
//   i_wr_data  : NCH-lane reference word
//   i_lat      : read-back distance in samples
//   o_rd_data  : delayed entry
//   o_fill     : valid entries written, saturating at DEPTH
// -----------------------------------------------------------------------------
module viterbi_hist_buf #(
    parameter  int NCH   = 1,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clr,
    input  logic           i_wr_en,
    input  logic [NCH-1:0] i_wr_data,
    input  logic [AW-1:0]  i_lat,
    output logic [NCH-1:0] o_rd_data,
    output logic [AW:0]    o_fill
);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [NCH-1:0] r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW:0]    r_fill;
    logic [AW-1:0]  w_rd_addr;

    // DEPTH is a power of two, so the subtraction wraps modulo DEPTH.
    assign w_rd_addr = r_wptr - i_lat;
    assign o_rd_data = (i_lat == '0) ? i_wr_data : r_mem[w_rd_addr];
    assign o_fill    = r_fill;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wptr <= '0;
            r_fill <= '0;
        end else if (i_wr_en) begin
            r_wptr <= r_wptr + 1'b1;
            if (r_fill != FULL) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // NOTE: the history array is deliberately not reset; o_fill gates every
    // use of it, and leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/viterbi_ber_checker.sv
// -----------------------------------------------------------------------------
// viterbi_ber_checker
// In-fabric scoreboard for the conv-encoder -> channel -> Viterbi chain.
// Each decoded word is compared against the reference recorded L samples
// earlier; good/bad bit counts accumulate while LOCKED. L is either fixed
// (auto_i = 0) or found by stepping L until LOCK_THR consecutive clean samples
// are seen (auto_i = 1); in auto mode a windowed loss check forces a relock.
//   clk, rst        : clock, synchronous active-high reset (beats start_i)
//   start_i         : start a run; samples auto_i and lat_cfg_i
//   stream          : sample stream (en_i, ref_i, dut_i), slave side
//   auto_i          : 0 = fixed latency, 1 = automatic search
//   lat_cfg_i       : fixed latency, or search start point
//   locked_o        : comparing and counting
//   lat_o           : latency in use
//   good_o / bad_o  : matching / mismatching bits counted while locked
//   sample_ct_o     : samples since start
//   relock_ct_o     : lock losses, saturating
//   sat_o           : sticky, some counter reached all-ones
//   first_err_*     : index and lane mask of the first counted mismatch
// Optional build macro VITERBI_CHK_ERR_LOG_EN enables the first-error capture;
// without it first_err_idx_o and first_err_lanes_o are tied to zero.
// -----------------------------------------------------------------------------
module viterbi_ber_checker
    import viterbi_chk_pkg::*;
#(
    parameter  int NCH      = 1,
    parameter  int DEPTH    = 64,
    parameter  int CNT_W    = 32,
    parameter  int LOCK_THR = 32,
    parameter  int LOSS_WIN = 16,
    parameter  int LOSS_THR = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    viterbi_chk_if.slave     stream,
    input  logic             auto_i,
    input  logic [AW-1:0]    lat_cfg_i,
    output logic             locked_o,
    output logic [AW-1:0]    lat_o,
    output logic [CNT_W-1:0] good_o,
    output logic [CNT_W-1:0] bad_o,
    output logic [CNT_W-1:0] sample_ct_o,
    output logic [7:0]       relock_ct_o,
    output logic             sat_o,
    output logic [CNT_W-1:0] first_err_idx_o,
    output logic [NCH-1:0]   first_err_lanes_o
);
    localparam int RUN_W = $clog2(LOCK_THR + 1);
    localparam int WIN_W = $clog2(LOSS_WIN + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    chk_state_e       r_state, w_state_nx;
    logic             r_locked;
    logic             r_auto, w_auto_nx;
    logic             r_sat, w_sat_nx;
    logic [AW-1:0]    r_lat, w_lat_nx;
    cnt_t             r_good, w_good_nx;
    cnt_t             r_bad, w_bad_nx;
    cnt_t             r_sample_ct, w_sample_ct_nx;
    relock_ct_t       r_relock_ct, w_relock_ct_nx;
    logic [RUN_W-1:0] r_run, w_run_nx;
    logic [WIN_W-1:0] r_win, w_win_nx;
    logic [WIN_W-1:0] r_miss, w_miss_nx, w_miss_sum;

    logic             w_smp, w_valid, w_count;
    logic [AW:0]      w_fill;
    logic [NCH-1:0]   w_hist, w_mask;
    cnt_t             w_bad_inc, w_good_inc;

    function automatic cnt_t sat_add(input cnt_t a, input cnt_t b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // A strobe coinciding with start_i belongs to the old run and is dropped.
    assign w_smp = stream.en_i && (r_state != ST_IDLE) && !start_i;

    viterbi_hist_buf #(
        .NCH   (NCH),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (start_i),
        .i_wr_en   (w_smp),
        .i_wr_data (stream.ref_i),
        .i_lat     (r_lat),
        .o_rd_data (w_hist),
        .o_fill    (w_fill)
    );

    // The entry L back exists once at least L samples precede this one.
    assign w_valid    = w_smp && (w_fill >= {1'b0, r_lat});
    assign w_mask     = stream.dut_i ^ w_hist;
    assign w_bad_inc  = cnt_t'(popcount(MAX_LANES'(w_mask), NCH));
    assign w_good_inc = cnt_t'(NCH) - w_bad_inc;
    assign w_miss_sum = r_miss + WIN_W'(|w_mask);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        w_state_nx     = r_state;
        w_auto_nx      = r_auto;
        w_lat_nx       = r_lat;
        w_good_nx      = r_good;
        w_bad_nx       = r_bad;
        w_sample_ct_nx = r_sample_ct;
        w_relock_ct_nx = r_relock_ct;
        w_run_nx       = r_run;
        w_win_nx       = r_win;
        w_miss_nx      = r_miss;
        w_sat_nx       = r_sat;
        w_count        = 1'b0;

        if (start_i) begin
            w_state_nx     = ST_FILL;
            w_auto_nx      = auto_i;
            w_lat_nx       = lat_cfg_i;
            w_good_nx      = '0;
            w_bad_nx       = '0;
            w_sample_ct_nx = '0;
            w_relock_ct_nx = '0;
            w_run_nx       = '0;
            w_win_nx       = '0;
            w_miss_nx      = '0;
            w_sat_nx       = 1'b0;
        end else if (w_smp) begin
            w_sample_ct_nx = sat_add(r_sample_ct, cnt_t'(1));
            if (w_valid) begin
                case (r_state)
                    ST_FILL, ST_SEARCH: begin
                        if (!r_auto) begin
                            // Fixed latency: the first comparable sample already counts.
                            w_state_nx = ST_LOCKED;
                            w_count    = 1'b1;
                        end else if (w_mask != '0) begin
                            // Wrong guess: try the next latency, wrapping past DEPTH-1.
                            w_lat_nx   = r_lat + 1'b1;
                            w_run_nx   = '0;
                            w_state_nx = ST_FILL;
                        end else if (r_run == RUN_W'(LOCK_THR - 1)) begin
                            w_state_nx = ST_LOCKED;
                            w_run_nx   = '0;
                            w_win_nx   = '0;
                            w_miss_nx  = '0;
                        end else begin
                            w_run_nx   = r_run + 1'b1;
                            w_state_nx = ST_SEARCH;
                        end
                    end
                    ST_LOCKED: begin
                        w_count = 1'b1;
                        if (r_auto) begin
                            if (r_win == WIN_W'(LOSS_WIN - 1)) begin
                                w_win_nx  = '0;
                                w_miss_nx = '0;
                                if (w_miss_sum >= WIN_W'(LOSS_THR)) begin
                                    w_state_nx     = ST_SEARCH;
                                    w_lat_nx       = r_lat + 1'b1;
                                    w_run_nx       = '0;
                                    w_relock_ct_nx = (r_relock_ct == '1) ? r_relock_ct
                                                                         : r_relock_ct + 1'b1;
                                end
                            end else begin
                                w_win_nx  = r_win + 1'b1;
                                w_miss_nx = w_miss_sum;
                            end
                        end
                    end
                    default: ;
                endcase
                if (w_count) begin
                    w_good_nx = sat_add(r_good, w_good_inc);
                    w_bad_nx  = sat_add(r_bad, w_bad_inc);
                end
            end
            w_sat_nx = r_sat | (&w_good_nx) | (&w_bad_nx) | (&w_sample_ct_nx) | (&w_relock_ct_nx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_locked    <= 1'b0;
            r_auto      <= 1'b0;
            r_lat       <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_sample_ct <= '0;
            r_relock_ct <= '0;
            r_run       <= '0;
            r_win       <= '0;
            r_miss      <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_locked    <= (w_state_nx == ST_LOCKED);
            r_auto      <= w_auto_nx;
            r_lat       <= w_lat_nx;
            r_good      <= w_good_nx;
            r_bad       <= w_bad_nx;
            r_sample_ct <= w_sample_ct_nx;
            r_relock_ct <= w_relock_ct_nx;
            r_run       <= w_run_nx;
            r_win       <= w_win_nx;
            r_miss      <= w_miss_nx;
            r_sat       <= w_sat_nx;
        end
    end

    assign locked_o    = r_locked;
    assign lat_o       = r_lat;
    assign good_o      = r_good;
    assign bad_o       = r_bad;
    assign sample_ct_o = r_sample_ct;
    assign relock_ct_o = r_relock_ct;
    assign sat_o       = r_sat;

`ifdef VITERBI_CHK_ERR_LOG_EN
    logic           r_err_seen;
    cnt_t           r_err_idx;
    logic [NCH-1:0] r_err_lanes;

    // Index is the sample count before the offending sample, i.e. its 0-based index.
    always_ff @(posedge clk) begin
        if (rst || start_i) begin
            r_err_seen  <= 1'b0;
            r_err_idx   <= '0;
            r_err_lanes <= '0;
        end else if (w_count && (w_mask != '0) && !r_err_seen) begin
            r_err_seen  <= 1'b1;
            r_err_idx   <= r_sample_ct;
            r_err_lanes <= w_mask;
        end
    end

    assign first_err_idx_o   = r_err_idx;
    assign first_err_lanes_o = r_err_lanes;
`else
    assign first_err_idx_o   = '0;
    assign first_err_lanes_o = '0;
`endif

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// -----------------------------------------------------------------------------
// tb_viterbi_ber_checker
// Self-checking bench for viterbi_ber_checker. Two checkers share one stimulus
// stream: dut (CNT_W = 32) and dut8 (CNT_W = 8, used for saturation).
// Honours VITERBI_CHK_ERR_LOG_EN for the first-error capture expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_viterbi_ber_checker;

    localparam int NCH   = 1;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, auto_mode;
    logic [AW-1:0]  lat_cfg;

    logic           locked, sat;
    logic [AW-1:0]  lat;
    logic [31:0]    good, bad, sct, ferr_idx;
    logic [7:0]     relock;
    logic [NCH-1:0] ferr_lanes;

    logic           s8_locked, s8_sat;
    logic [AW-1:0]  s8_lat;
    logic [7:0]     s8_good, s8_bad, s8_sct, s8_ferr_idx, s8_relock;
    logic [NCH-1:0] s8_ferr_lanes;

    viterbi_chk_if #(.NCH(NCH)) stream_if ();

    viterbi_ber_checker #(.NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start), .stream(stream_if),
        .auto_i(auto_mode), .lat_cfg_i(lat_cfg),
        .locked_o(locked), .lat_o(lat), .good_o(good), .bad_o(bad),
        .sample_ct_o(sct), .relock_ct_o(relock), .sat_o(sat),
        .first_err_idx_o(ferr_idx), .first_err_lanes_o(ferr_lanes)
    );

    viterbi_ber_checker #(.NCH(NCH), .DEPTH(DEPTH), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start), .stream(stream_if),
        .auto_i(auto_mode), .lat_cfg_i(lat_cfg),
        .locked_o(s8_locked), .lat_o(s8_lat), .good_o(s8_good), .bad_o(s8_bad),
        .sample_ct_o(s8_sct), .relock_ct_o(s8_relock), .sat_o(s8_sat),
        .first_err_idx_o(s8_ferr_idx), .first_err_lanes_o(s8_ferr_lanes)
    );

    typedef struct {
        logic [31:0] good;
        logic [31:0] bad;
        logic [31:0] sct;
        logic        locked;
    } exp_t;

    exp_t           sb[$];
    logic [NCH-1:0] ref_hist[$];
    int             flip_at[$];
    int             vectors = 0;
    int             miscompares = 0;

    // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
    task automatic drive_sample(input logic [NCH-1:0] r, input logic [NCH-1:0] d);
        @(negedge clk);
        stream_if.en_i  = 1'b1;
        stream_if.ref_i = r;
        stream_if.dut_i = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic a, input logic [AW-1:0] l);
        @(negedge clk);
        start          = 1'b1;
        auto_mode      = a;
        lat_cfg        = l;
        stream_if.en_i = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Fixed-latency run: dut is ref delayed by l samples, with lanes flipped at
    // the indices in flip_at. Each sample's expected counters go through sb.
    task automatic run_fixed(input string tag, input int n, input int l);
        exp_t           e;
        logic [NCH-1:0] r, d, h;
        int             n_good, n_bad;
        n_good = 0;
        n_bad  = 0;
        ref_hist.delete();
        do_start(1'b0, AW'(l));
        for (int k = 0; k < n; k++) begin
            r = NCH'($urandom);
            ref_hist.push_back(r);
            if (k >= l) begin
                h = ref_hist[k - l];
                d = h;
                foreach (flip_at[j]) if (flip_at[j] == k) d = ~d;
                n_bad  += $countones(d ^ h);
                n_good += NCH - $countones(d ^ h);
            end else begin
                d = NCH'($urandom);
            end
            e.good   = 32'(n_good);
            e.bad    = 32'(n_bad);
            e.sct    = 32'(k + 1);
            e.locked = (k >= l);
            sb.push_back(e);
            drive_sample(r, d);
            e = sb.pop_front();
            vectors++;
            if ({good, bad, sct, locked} !== {e.good, e.bad, e.sct, e.locked}) begin
                miscompares++;
                $display("FAIL %s sample %0d: good/bad/sct/locked got %0d/%0d/%0d/%0b want %0d/%0d/%0d/%0b",
                         tag, k, good, bad, sct, locked, e.good, e.bad, e.sct, e.locked);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({locked, lat, good, bad, sct, relock, sat, ferr_idx, ferr_lanes} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: locked=%0b lat=%0d good=%0d bad=%0d sct=%0d relock=%0d sat=%0b want all 0",
                     locked, lat, good, bad, sct, relock, sat);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fixed_latency();
        flip_at.delete();
        run_fixed("fixed", 200, 5);
        vectors++;
        if ({good, bad, sct} !== {32'd195, 32'd0, 32'd200}) begin
            miscompares++;
            $display("FAIL fixed_totals: good/bad/sct got %0d/%0d/%0d want 195/0/200", good, bad, sct);
        end
        vectors++;
        if ({locked, lat, sat} !== {1'b1, 6'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL fixed_status: locked/lat/sat got %0b/%0d/%0b want 1/5/0", locked, lat, sat);
        end
        vectors++;
        if ({ferr_idx, ferr_lanes} !== '0) begin
            miscompares++;
            $display("FAIL fixed_no_err_log: idx/lanes got %0d/%0d want 0/0", ferr_idx, ferr_lanes);
        end
    endtask

    task automatic test_error_count();
        flip_at = '{50, 51, 120};
        run_fixed("flips", 200, 5);
        flip_at.delete();
        vectors++;
        if ({good, bad} !== {32'd192, 32'd3}) begin
            miscompares++;
            $display("FAIL flips_totals: good/bad got %0d/%0d want 192/3", good, bad);
        end
`ifdef VITERBI_CHK_ERR_LOG_EN
        vectors++;
        if ({ferr_idx, ferr_lanes} !== {32'd50, 1'b1}) begin
            miscompares++;
            $display("FAIL err_log: idx/lanes got %0d/%0d want 50/1", ferr_idx, ferr_lanes);
        end
`else
        vectors++;
        if ({ferr_idx, ferr_lanes} !== '0) begin
            miscompares++;
            $display("FAIL err_log_tied: idx/lanes got %0d/%0d want 0/0", ferr_idx, ferr_lanes);
        end
`endif
    endtask

    task automatic test_auto_search();
        logic [NCH-1:0] r, d;
        ref_hist.delete();
        do_start(1'b1, '0);
        for (int k = 0; k < 400; k++) begin
            r = NCH'($urandom);
            ref_hist.push_back(r);
            d = (k >= 12) ? ref_hist[k - 12] : NCH'($urandom);
            drive_sample(r, d);
        end
        vectors++;
        if ({locked, lat} !== {1'b1, 6'd12}) begin
            miscompares++;
            $display("FAIL auto_lock: locked/lat got %0b/%0d want 1/12", locked, lat);
        end
        vectors++;
        if ({bad, relock, sct} !== {32'd0, 8'd0, 32'd400}) begin
            miscompares++;
            $display("FAIL auto_counts: bad/relock/sct got %0d/%0d/%0d want 0/0/400", bad, relock, sct);
        end
    endtask

    // Continues the locked run above: 20 inverted samples, then clean data.
    task automatic test_relock();
        logic [NCH-1:0] r, d;
        int             base, unlock_at;
        base      = ref_hist.size();
        unlock_at = -1;
        for (int i = 0; i < 820; i++) begin
            r = NCH'($urandom);
            ref_hist.push_back(r);
            d = ref_hist[base + i - 12];
            if (i < 20) d = ~d;
            drive_sample(r, d);
            if (unlock_at < 0 && !locked) unlock_at = i;
        end
        vectors++;
        if (unlock_at < 0 || unlock_at >= 32) begin
            miscompares++;
            $display("FAIL relock_unlock: first unlocked sample %0d want 0..31", unlock_at);
        end
        vectors++;
        if ({relock, locked, lat} !== {8'd1, 1'b1, 6'd12}) begin
            miscompares++;
            $display("FAIL relock_final: relock/locked/lat got %0d/%0b/%0d want 1/1/12", relock, locked, lat);
        end
    endtask

    task automatic test_saturation();
        exp_t        e;
        logic [NCH-1:0] r;
        do_start(1'b0, '0);
        for (int k = 0; k < 300; k++) begin
            r = NCH'($urandom);
            e.good   = (k + 1 > 255) ? 32'd255 : 32'(k + 1);
            e.bad    = 32'd0;
            e.sct    = e.good;
            e.locked = 1'b1;
            sb.push_back(e);
            drive_sample(r, r);
            e = sb.pop_front();
            vectors++;
            if ({s8_good, s8_bad, s8_sct, s8_locked} !== {e.good[7:0], e.bad[7:0], e.sct[7:0], e.locked}) begin
                miscompares++;
                $display("FAIL sat8 sample %0d: good/bad/sct/locked got %0d/%0d/%0d/%0b want %0d/%0d/%0d/%0b",
                         k, s8_good, s8_bad, s8_sct, s8_locked, e.good, e.bad, e.sct, e.locked);
            end
            if (k + 1 != 255) begin
                vectors++;
                if (s8_sat !== (k + 1 > 255)) begin
                    miscompares++;
                    $display("FAIL sat8_flag sample %0d: got %0b want %0b", k, s8_sat, (k + 1 > 255));
                end
            end
        end
        do_start(1'b0, '0);
        vectors++;
        if ({s8_good, s8_sct, s8_sat} !== {8'd0, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL sat8_clear: good/sct/sat got %0d/%0d/%0b want 0/0/0", s8_good, s8_sct, s8_sat);
        end
    endtask

    task automatic test_start_rst();
        run_fixed("pre_rst", 10, 3);
        @(negedge clk);
        rst            = 1'b1;
        start          = 1'b1;
        auto_mode      = 1'b1;
        lat_cfg        = 6'd9;
        stream_if.en_i = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({locked, lat, good, bad, sct, relock, sat} !== '0 ||
            {s8_locked, s8_lat, s8_good, s8_sct, s8_sat} !== '0) begin
            miscompares++;
            $display("FAIL rst_beats_start: locked=%0b lat=%0d good=%0d bad=%0d sct=%0d sat=%0b want all 0",
                     locked, lat, good, bad, sct, sat);
        end
        @(negedge clk);
        rst            = 1'b0;
        start          = 1'b0;
        stream_if.en_i = 1'b0;

        run_fixed("pre_start", 10, 3);
        @(negedge clk);
        start           = 1'b1;
        auto_mode       = 1'b0;
        lat_cfg         = 6'd7;
        stream_if.en_i  = 1'b1;
        stream_if.ref_i = 1'b1;
        stream_if.dut_i = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if ({sct, good, bad, locked, lat} !== {32'd0, 32'd0, 32'd0, 1'b0, 6'd7}) begin
            miscompares++;
            $display("FAIL start_with_en: sct/good/bad/locked/lat got %0d/%0d/%0d/%0b/%0d want 0/0/0/0/7",
                     sct, good, bad, locked, lat);
        end
        drive_sample(1'b0, 1'b1);
        vectors++;
        if ({sct, locked} !== {32'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL start_then_sample: sct/locked got %0d/%0b want 1/0", sct, locked);
        end
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        auto_mode       = 1'b0;
        lat_cfg         = '0;
        stream_if.en_i  = 1'b0;
        stream_if.ref_i = '0;
        stream_if.dut_i = '0;

        test_reset();
        test_fixed_latency();
        test_error_count();
        test_auto_search();
        test_relock();
        test_saturation();
        test_start_rst();

        @(negedge clk);
        stream_if.en_i = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
